lsu_sequencer: RTL and testbench

// Multi-cycle load/store sequencer between the core's decoded memory controls and a word-wide req/ack data bus.

---
 rtl/lsu_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_lsu_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_sequencer.sv
// Load/store sequencer: latches one access per start, runs 1-2 bus beats, returns extended load data.
// Build option MISALIGN_SPLIT_EN: split word-crossing H/W accesses into two beats instead of faulting.
module lsu_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        rw,
    input  logic [2:0]  func,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    localparam int TW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_BEAT0, S_BEAT1, S_RESP} state_e;

    state_e        state_q, state_d;
    logic          rw_q, rw_d;
    logic [2:0]    func_q, func_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   r0_q, r0_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;

    logic [1:0]    ofs;
    logic [7:0]    base, mask;
    logic [31:0]   wrep, word;
    logic [63:0]   wsh, lw64;
    logic [31:0]   raw, ld_ext;
    logic          bad_func, misalign, two_beat, timeout;
    logic [TW-1:0] tmo_inc;

    assign ofs  = addr_q[1:0];
    assign word = {addr_q[31:2], 2'b00};

    // Lane masks/data span two words so a crossing access just takes the upper half for beat 1.
    always_comb begin
        case (func_q[1:0])
            2'b00:   begin base = 8'h01; wrep = {4{wdata_q[7:0]}};  end
            2'b01:   begin base = 8'h03; wrep = {2{wdata_q[15:0]}}; end
            default: begin base = 8'h0F; wrep = wdata_q;            end
        endcase
        mask = base << ofs;
        wsh  = {wrep, wrep} << {ofs, 3'b000};
    end

    assign bad_func = (func_q == 3'b011) || (func_q[2:1] == 2'b11) || (rw_q && func_q[2]);

`ifdef MISALIGN_SPLIT_EN
    assign misalign = 1'b0;
    assign two_beat = |mask[7:4];
`else
    assign misalign = ((func_q[1:0] == 2'b01) && ofs[0]) || ((func_q[1:0] == 2'b10) && (ofs != 2'b00));
    assign two_beat = 1'b0;
`endif

    // Beat-0 word sits below the beat-1 word, so bytes come out low-to-high after the shift.
    always_comb begin
        lw64 = (state_q == S_BEAT1) ? {bus_rdata, r0_q} : {32'h0, bus_rdata};
        raw  = 32'(lw64 >> {ofs, 3'b000});
        case (func_q)
            3'b000:  ld_ext = {{24{raw[7]}}, raw[7:0]};
            3'b001:  ld_ext = {{16{raw[15]}}, raw[15:0]};
            3'b100:  ld_ext = {24'h0, raw[7:0]};
            3'b101:  ld_ext = {16'h0, raw[15:0]};
            default: ld_ext = raw;
        endcase
    end

    assign tmo_inc = (&tmo_q) ? tmo_q : tmo_q + TW'(1);
    assign timeout = (TIMEOUT_CYCLES != 0) && (tmo_inc == TW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d = state_q;
        rw_d    = rw_q;
        func_d  = func_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tmo_d   = tmo_q;
        r0_d    = r0_q;
        rdata_d = rdata_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    rw_d    = rw;
                    func_d  = func;
                    addr_d  = addr;
                    wdata_d = wdata;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                tmo_d = '0;
                if (bad_func || misalign) begin
                    fault_d = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    state_d = S_BEAT0;
                end
            end
            S_BEAT0, S_BEAT1: begin
                if (bus_ack) begin
                    if (bus_err) begin
                        fault_d = 1'b1;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end else if (state_q == S_BEAT0 && two_beat) begin
                        r0_d    = bus_rdata;
                        tmo_d   = '0;
                        state_d = S_BEAT1;
                    end else begin
                        fault_d = 1'b0;
                        rdata_d = rw_q ? 32'h0 : ld_ext;
                        state_d = S_RESP;
                    end
                end else if (timeout) begin
                    fault_d = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_RESP: begin
                fault_d = 1'b0;
                rdata_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rw_q    <= 1'b0;
            func_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tmo_q   <= '0;
            r0_q    <= '0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            func_q  <= func_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tmo_q   <= tmo_d;
            r0_q    <= r0_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_RESP);
    assign fault = fault_q;
    assign rdata = rdata_q;

    // Bus outputs decode straight from state so an async reset drops req in the same instant.
    always_comb begin
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_be    = '0;
        bus_wdata = '0;
        if (state_q == S_BEAT0) begin
            bus_req   = 1'b1;
            bus_we    = rw_q;
            bus_addr  = word;
            bus_be    = mask[3:0];
            bus_wdata = wsh[31:0];
        end else if (state_q == S_BEAT1) begin
            bus_req   = 1'b1;
            bus_we    = rw_q;
            bus_addr  = word + 32'd4;
            bus_be    = mask[7:4];
            bus_wdata = wsh[63:32];
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer; a cycle-stepped bus responder acks beats after a set delay.
module tb_lsu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        rw = 1'b0;
    logic [2:0]  func = 3'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        busy, done, fault;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err = 1'b0;

    int total = 0;
    int bad = 0;

    lsu_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .func(func), .addr(addr),
        .wdata(wdata), .busy(busy), .done(done), .fault(fault), .rdata(rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    // Results of the most recent access.
    logic        got_done, r_fault, r_busy, we0, unstable;
    logic [31:0] r_rdata, a0, a1, wd0, cur_addr;
    logic [3:0]  be0, be1, cur_be;
    int          first_req, ack_c, done_c, nbeats, req_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic r, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                       input int dly, input logic [31:0] w0, input logic [31:0] w1,
                       input logic e, input logic poke);
        int c, wait_n;
        @(posedge clk); #1;
        rw = r; func = f; addr = a; wdata = wd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1; wait_n = 0;
        got_done = 0; r_fault = 0; r_busy = 0; r_rdata = '0; unstable = 0;
        a0 = '0; a1 = '0; wd0 = '0; be0 = '0; be1 = '0; we0 = 0; cur_addr = '0; cur_be = '0;
        first_req = -1; ack_c = -1; done_c = -1; nbeats = 0; req_cycles = 0;
        for (int i = 0; i < 60 && !got_done; i++) begin
            if (done) begin
                got_done = 1; done_c = c; r_rdata = rdata; r_fault = fault; r_busy = busy;
            end else begin
                if (bus_req) begin
                    req_cycles++;
                    if (first_req < 0) first_req = c;
                    if (poke) begin start = 1'b1; addr = 32'h200; rw = 1'b1; end
                    if (wait_n == 0) begin
                        cur_addr = bus_addr; cur_be = bus_be;
                        if (nbeats == 0) begin be0 = bus_be; a0 = bus_addr; we0 = bus_we; wd0 = bus_wdata; end
                        else begin be1 = bus_be; a1 = bus_addr; end
                    end else if (bus_addr !== cur_addr || bus_be !== cur_be) begin
                        unstable = 1;
                    end
                    if (wait_n >= dly) begin
                        bus_ack = 1'b1; bus_rdata = (nbeats == 0) ? w0 : w1; bus_err = e;
                        ack_c = c; nbeats++; wait_n = 0;
                    end else begin
                        wait_n++;
                    end
                end
                @(posedge clk); #1;
                bus_ack = 1'b0; bus_err = 1'b0; start = 1'b0;
                c++;
            end
        end
        chk("done_seen", 32'(got_done), 32'd1);
    endtask

    initial begin
        logic       saw;
        logic [3:0] rst_vec;
        #12;
        chk("reset_outputs", {busy, done, fault, bus_req, bus_we, bus_be, rdata[26:0]}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // LW aligned, ack 2 cycles after req
        run(1'b0, 3'b010, 32'h100, 32'h0, 2, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        chk("lw_req_latency", 32'(first_req), 32'd2);
        chk("lw_ack_cycle", 32'(ack_c), 32'd4);
        chk("lw_done_latency", 32'(done_c), 32'(ack_c + 1));
        chk("lw_be", {28'h0, be0}, 32'hF);
        chk("lw_addr", a0, 32'h100);
        chk("lw_we", 32'(we0), 32'd0);
        chk("lw_rdata", r_rdata, 32'hDEADBEEF);
        chk("lw_fault", 32'(r_fault), 32'd0);
        chk("lw_busy_at_done", 32'(r_busy), 32'd1);
        chk("lw_stable", 32'(unstable), 32'd0);
        @(posedge clk); #1;
        chk("lw_idle_after", {30'h0, busy, done}, 32'h0);

        run(1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80123456, 32'h0, 1'b0, 1'b0);
        chk("lb_be", {28'h0, be0}, 32'h8);
        chk("lb_rdata", r_rdata, 32'hFFFFFF80);
        run(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80123456, 32'h0, 1'b0, 1'b0);
        chk("lbu_rdata", r_rdata, 32'h00000080);

        run(1'b0, 3'b001, 32'h102, 32'h0, 0, 32'h80011234, 32'h0, 1'b0, 1'b0);
        chk("lh_be", {28'h0, be0}, 32'hC);
        chk("lh_rdata", r_rdata, 32'hFFFF8001);
        run(1'b0, 3'b101, 32'h102, 32'h0, 0, 32'h80011234, 32'h0, 1'b0, 1'b0);
        chk("lhu_rdata", r_rdata, 32'h00008001);

        run(1'b1, 3'b001, 32'h102, 32'h1234BEEF, 1, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sh_we", 32'(we0), 32'd1);
        chk("sh_addr", a0, 32'h100);
        chk("sh_be", {28'h0, be0}, 32'hC);
        chk("sh_wdata_hi", {16'h0, wd0[31:16]}, 32'h0000BEEF);
        chk("sh_rdata", r_rdata, 32'h0);
        chk("sh_fault", 32'(r_fault), 32'd0);

        run(1'b1, 3'b000, 32'h101, 32'h000000AB, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("sb_be", {28'h0, be0}, 32'h2);
        chk("sb_wdata", wd0, 32'hABABAB00);

`ifdef MISALIGN_SPLIT_EN
        run(1'b0, 3'b010, 32'h102, 32'h0, 0, 32'hAABBCCDD, 32'h11223344, 1'b0, 1'b0);
        chk("lw_split_beats", 32'(nbeats), 32'd2);
        chk("lw_split_be0", {28'h0, be0}, 32'hC);
        chk("lw_split_be1", {28'h0, be1}, 32'h3);
        chk("lw_split_a1", a1, 32'h104);
        chk("lw_split_rdata", r_rdata, 32'h3344AABB);
        run(1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h00ABCD00, 32'h0, 1'b0, 1'b0);
        chk("lh_a1_beats", 32'(nbeats), 32'd1);
        chk("lh_a1_be", {28'h0, be0}, 32'h6);
        chk("lh_a1_rdata", r_rdata, 32'hFFFFABCD);
        run(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("wrap_a0", a0, 32'hFFFFFFFC);
        chk("wrap_a1", a1, 32'h0);
`else
        run(1'b0, 3'b010, 32'h102, 32'h0, 0, 32'hAABBCCDD, 32'h11223344, 1'b0, 1'b0);
        chk("lw_misalign_fault", 32'(r_fault), 32'd1);
        chk("lw_misalign_noreq", 32'(req_cycles), 32'd0);
        run(1'b0, 3'b001, 32'h101, 32'h0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("lh_misalign_fault", 32'(r_fault), 32'd1);
        chk("lh_misalign_noreq", 32'(req_cycles), 32'd0);
`endif

        run(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("badfunc_fault", 32'(r_fault), 32'd1);
        chk("badfunc_noreq", 32'(req_cycles), 32'd0);
        chk("badfunc_done_cycle", 32'(done_c), 32'd2);
        chk("badfunc_rdata", r_rdata, 32'h0);

        run(1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("store_bu_fault", 32'(r_fault), 32'd1);
        chk("store_bu_noreq", 32'(req_cycles), 32'd0);

        run(1'b0, 3'b010, 32'h100, 32'h0, 1, 32'h12345678, 32'h0, 1'b1, 1'b0);
        chk("buserr_fault", 32'(r_fault), 32'd1);
        chk("buserr_rdata", r_rdata, 32'h0);

        run(1'b0, 3'b010, 32'h100, 32'h0, 100, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("timeout_req_cycles", 32'(req_cycles), 32'd4);
        chk("timeout_fault", 32'(r_fault), 32'd1);

        // start pulses while busy must not disturb the access or queue another
        run(1'b0, 3'b010, 32'h100, 32'h0, 3, 32'h01020304, 32'h0, 1'b0, 1'b1);
        chk("poke_addr", a0, 32'h100);
        chk("poke_stable", 32'(unstable), 32'd0);
        chk("poke_rdata", r_rdata, 32'h01020304);
        @(posedge clk); #1;
        saw = busy | done | bus_req;
        @(posedge clk); #1;
        saw = saw | busy | done | bus_req;
        chk("poke_ignored", 32'(saw), 32'd0);

        // reset while in BEAT0
        @(posedge clk); #1;
        rw = 1'b0; func = 3'b010; addr = 32'h100; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1;
        chk("rst_pre_req", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 rst_vec = {bus_req, busy, done, fault};
        chk("rst_immediate", {28'h0, rst_vec}, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            saw = saw | done | bus_req | busy;
        end
        chk("rst_no_done", 32'(saw), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
